// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: ID-side fields and WB write port in, EX-side register image out.
// The ID/decode side uses the master modport; the operand stage uses the slave modport.
interface id_ex_operand_stage_if #(
    parameter int N      = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic [N-1:0]      ReadData1_i;
    logic [N-1:0]      ReadData2_i;
    logic [4:0]        rs_i;
    logic [4:0]        rt_i;
    logic [4:0]        rd_i;
    logic              uses_rt_i;
    logic [N-1:0]      imm_i;
    logic              RegWrite_i;
    logic              MemRead_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              flush_i;
    logic              wb_RegWrite_i;
    logic [4:0]        wb_WriteRegister_i;
    logic [N-1:0]      wb_WriteData_i;

    logic              stall_o;
    logic              ex_valid_o;
    logic [N-1:0]      ex_ReadData1_o;
    logic [N-1:0]      ex_ReadData2_o;
    logic [4:0]        ex_rs_o;
    logic [4:0]        ex_rt_o;
    logic [4:0]        ex_rd_o;
    logic [N-1:0]      ex_imm_o;
    logic              ex_RegWrite_o;
    logic              ex_MemRead_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic [CNT_W-1:0]  stall_count_o;

    modport master (
        output ReadData1_i, ReadData2_i, rs_i, rt_i, rd_i, uses_rt_i, imm_i,
               RegWrite_i, MemRead_i, ctrl_i, flush_i,
               wb_RegWrite_i, wb_WriteRegister_i, wb_WriteData_i,
        input  stall_o, ex_valid_o, ex_ReadData1_o, ex_ReadData2_o, ex_rs_o, ex_rt_o,
               ex_rd_o, ex_imm_o, ex_RegWrite_o, ex_MemRead_o, ex_ctrl_o, stall_count_o
    );

    modport slave (
        input  ReadData1_i, ReadData2_i, rs_i, rt_i, rd_i, uses_rt_i, imm_i,
               RegWrite_i, MemRead_i, ctrl_i, flush_i,
               wb_RegWrite_i, wb_WriteRegister_i, wb_WriteData_i,
        output stall_o, ex_valid_o, ex_ReadData1_o, ex_ReadData2_o, ex_rs_o, ex_rt_o,
               ex_rd_o, ex_imm_o, ex_RegWrite_o, ex_MemRead_o, ex_ctrl_o, stall_count_o
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register with load-use stall, branch flush and saturating stall counter.
// Optional macro ID_EX_WB_BYPASS_EN forwards the WB write port into the captured operands.
module id_ex_operand_stage #(
    parameter int N      = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    id_ex_operand_stage_if.slave    bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_valid;
    logic              r_RegWrite;
    logic              r_MemRead;
    logic [N-1:0]      r_ReadData1;
    logic [N-1:0]      r_ReadData2;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [N-1:0]      r_imm;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_hazard;
    logic              w_stall;
    logic [N-1:0]      w_op_a;
    logic [N-1:0]      w_op_b;

    // A load in EX whose destination is read by ID; $zero never counts as a dependency.
    assign w_hazard = r_valid & r_MemRead & (r_rt != 5'd0) &
                      ((r_rt == bus.rs_i) | (bus.uses_rt_i & (r_rt == bus.rt_i)));
    assign w_stall  = w_hazard & ~bus.flush_i & ~reset;

`ifdef ID_EX_WB_BYPASS_EN
    logic w_wb_live;
    assign w_wb_live = bus.wb_RegWrite_i & (bus.wb_WriteRegister_i != 5'd0);
    assign w_op_a = (w_wb_live && bus.wb_WriteRegister_i == bus.rs_i) ? bus.wb_WriteData_i
                                                                      : bus.ReadData1_i;
    assign w_op_b = (w_wb_live && bus.wb_WriteRegister_i == bus.rt_i) ? bus.wb_WriteData_i
                                                                      : bus.ReadData2_i;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{bus.wb_RegWrite_i, bus.wb_WriteRegister_i, bus.wb_WriteData_i};
    assign w_op_a = bus.ReadData1_i;
    assign w_op_b = bus.ReadData2_i;
`endif

    // Bubbles clear only the qualifying control; data fields keep their last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_RegWrite    <= 1'b0;
            r_MemRead     <= 1'b0;
            r_ctrl        <= '0;
            r_ReadData1   <= '0;
            r_ReadData2   <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_imm         <= '0;
            r_stall_count <= '0;
        end else if (bus.flush_i || w_hazard) begin
            r_valid    <= 1'b0;
            r_RegWrite <= 1'b0;
            r_MemRead  <= 1'b0;
            r_ctrl     <= '0;
            if (!bus.flush_i && r_stall_count != CNT_MAX) begin
                r_stall_count <= r_stall_count + CNT_ONE;
            end
        end else begin
            r_valid     <= 1'b1;
            r_RegWrite  <= bus.RegWrite_i;
            r_MemRead   <= bus.MemRead_i;
            r_ctrl      <= bus.ctrl_i;
            r_ReadData1 <= w_op_a;
            r_ReadData2 <= w_op_b;
            r_rs        <= bus.rs_i;
            r_rt        <= bus.rt_i;
            r_rd        <= bus.rd_i;
            r_imm       <= bus.imm_i;
        end
    end

    assign bus.stall_o        = w_stall;
    assign bus.ex_valid_o     = r_valid;
    assign bus.ex_ReadData1_o = r_ReadData1;
    assign bus.ex_ReadData2_o = r_ReadData2;
    assign bus.ex_rs_o        = r_rs;
    assign bus.ex_rt_o        = r_rt;
    assign bus.ex_rd_o        = r_rd;
    assign bus.ex_imm_o       = r_imm;
    assign bus.ex_RegWrite_o  = r_RegWrite;
    assign bus.ex_MemRead_o   = r_MemRead;
    assign bus.ex_ctrl_o      = r_ctrl;
    assign bus.stall_count_o  = r_stall_count;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: reference model of the EX register plus directed vectors.
// A second instance with a 2-bit counter shares the same stimulus to exercise saturation.
module tb_id_ex_operand_stage;
`ifdef ID_EX_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.N(32), .CTRL_W(8), .CNT_W(16)) bus ();
    id_ex_operand_stage_if #(.N(32), .CTRL_W(8), .CNT_W(2))  bus2 ();

    id_ex_operand_stage #(.N(32), .CTRL_W(8), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
    id_ex_operand_stage #(.N(32), .CTRL_W(8), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign bus2.ReadData1_i        = bus.ReadData1_i;
    assign bus2.ReadData2_i        = bus.ReadData2_i;
    assign bus2.rs_i               = bus.rs_i;
    assign bus2.rt_i               = bus.rt_i;
    assign bus2.rd_i               = bus.rd_i;
    assign bus2.uses_rt_i          = bus.uses_rt_i;
    assign bus2.imm_i              = bus.imm_i;
    assign bus2.RegWrite_i         = bus.RegWrite_i;
    assign bus2.MemRead_i          = bus.MemRead_i;
    assign bus2.ctrl_i             = bus.ctrl_i;
    assign bus2.flush_i            = bus.flush_i;
    assign bus2.wb_RegWrite_i      = bus.wb_RegWrite_i;
    assign bus2.wb_WriteRegister_i = bus.wb_WriteRegister_i;
    assign bus2.wb_WriteData_i     = bus.wb_WriteData_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what EX should contain, and how many stalls have been taken.
    typedef struct {
        bit          v;
        bit          rw;
        bit          mr;
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
    } ex_t;

    ex_t         m = '{default: '0};
    int unsigned m_stalls = 0;

    function automatic bit load_use();
        return m.v && m.mr && m.rt != 0 &&
               (m.rt == bus.rs_i || (bus.uses_rt_i && m.rt == bus.rt_i));
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
        if (BYP && bus.wb_RegWrite_i && bus.wb_WriteRegister_i != 0 && bus.wb_WriteRegister_i == idx)
            return bus.wb_WriteData_i;
        return rf;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m = '{default: '0};
            m_stalls = 0;
        end else if (bus.flush_i || load_use()) begin
            if (!bus.flush_i) m_stalls++;
            m.v = 0; m.rw = 0; m.mr = 0; m.ctrl = 0;
        end else begin
            m.v = 1; m.rw = bus.RegWrite_i; m.mr = bus.MemRead_i; m.ctrl = bus.ctrl_i;
            m.a = operand(bus.rs_i, bus.ReadData1_i);
            m.b = operand(bus.rt_i, bus.ReadData2_i);
            m.rs = bus.rs_i; m.rt = bus.rt_i; m.rd = bus.rd_i; m.imm = bus.imm_i;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_stall", bus.stall_o, load_use() && !bus.flush_i);
            chk("m_valid", bus.ex_valid_o, m.v);
            chk("m_rw", bus.ex_RegWrite_o, m.rw);
            chk("m_mr", bus.ex_MemRead_o, m.mr);
            chk("m_ctrl", bus.ex_ctrl_o, m.ctrl);
            chk("m_rd1", bus.ex_ReadData1_o, m.a);
            chk("m_rd2", bus.ex_ReadData2_o, m.b);
            chk("m_imm", bus.ex_imm_o, m.imm);
            chk("m_idx", {bus.ex_rs_o, bus.ex_rt_o, bus.ex_rd_o}, {m.rs, m.rt, m.rd});
            chk("m_cnt16", bus.stall_count_o, (m_stalls > 65535) ? 65535 : m_stalls);
            chk("m_cnt2", bus2.stall_count_o, (m_stalls > 3) ? 3 : m_stalls);
            chk("m_stall2", bus2.stall_o, bus.stall_o);
        end
    end

    task automatic id_in(input logic [4:0] rs, rt, rd, input logic use_rt,
                         input logic [31:0] a, b, imm, input logic rw, mr,
                         input logic [7:0] ctrl, input logic fl);
        bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd; bus.uses_rt_i = use_rt;
        bus.ReadData1_i = a; bus.ReadData2_i = b; bus.imm_i = imm;
        bus.RegWrite_i = rw; bus.MemRead_i = mr; bus.ctrl_i = ctrl; bus.flush_i = fl;
    endtask

    task automatic lw(input logic [4:0] rt);
        id_in(5'd1, rt, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 8'h3C, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        id_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.wb_RegWrite_i = 0; bus.wb_WriteRegister_i = 0; bus.wb_WriteData_i = 0;
        #11;
        chk("rst_valid", bus.ex_valid_o, 1'b0);
        chk("rst_stall", bus.stall_o, 1'b0);
        chk("rst_cnt", bus.stall_count_o, 16'd0);
        reset = 1'b0;

        // Plain pass
        id_in(5'd8, 5'd9, 5'd10, 1'b1, 32'h1234, 32'hABCD, 32'hFFFF_FFF8, 1'b1, 1'b0, 8'hA5, 1'b0);
        #1 chk("pass_stall", bus.stall_o, 1'b0);
        step();
        chk("pass_rd1", bus.ex_ReadData1_o, 32'h1234);
        chk("pass_rd2", bus.ex_ReadData2_o, 32'hABCD);
        chk("pass_valid", bus.ex_valid_o, 1'b1);
        chk("pass_ctrl", bus.ex_ctrl_o, 8'hA5);

        // Load-use on rs
        lw(5'd16);
        step();
        id_in(5'd16, 5'd2, 5'd3, 1'b1, 32'h77, 32'h88, 32'h0, 1'b1, 1'b0, 8'h11, 1'b0);
        #1 chk("lu_stall", bus.stall_o, 1'b1);
        step();
        chk("lu_bubble", bus.ex_valid_o, 1'b0);
        chk("lu_cnt", bus.stall_count_o, 16'd1);
        chk("lu_keep_rs", bus.ex_rs_o, 5'd1);
        chk("lu_stall_clr", bus.stall_o, 1'b0);
        step();
        chk("lu_cap_rs", bus.ex_rs_o, 5'd16);
        chk("lu_cap_rd1", bus.ex_ReadData1_o, 32'h77);
        chk("lu_cap_valid", bus.ex_valid_o, 1'b1);

        // Flush beats hazard
        lw(5'd16);
        step();
        id_in(5'd16, 5'd2, 5'd3, 1'b1, 32'h99, 32'h88, 32'h0, 1'b1, 1'b0, 8'h22, 1'b1);
        #1 chk("fl_stall", bus.stall_o, 1'b0);
        step();
        chk("fl_valid", bus.ex_valid_o, 1'b0);
        chk("fl_cnt", bus.stall_count_o, 16'd1);
        chk("fl_ctrl", bus.ex_ctrl_o, 8'h00);

        // $zero destination and unused rt
        lw(5'd0);
        step();
        id_in(5'd0, 5'd0, 5'd4, 1'b1, 32'h5, 32'h6, 32'h0, 1'b1, 1'b0, 8'h01, 1'b0);
        #1 chk("zero_stall", bus.stall_o, 1'b0);
        step();
        lw(5'd9);
        step();
        id_in(5'd3, 5'd9, 5'd4, 1'b0, 32'h5, 32'h6, 32'h0, 1'b1, 1'b0, 8'h02, 1'b0);
        #1 chk("nort_stall", bus.stall_o, 1'b0);
        step();
        chk("nort_valid", bus.ex_valid_o, 1'b1);

        // Hazard through rt when rt is a source
        lw(5'd9);
        step();
        id_in(5'd3, 5'd9, 5'd4, 1'b1, 32'h5, 32'h6, 32'h0, 1'b1, 1'b0, 8'h03, 1'b0);
        #1 chk("rt_stall", bus.stall_o, 1'b1);
        step();
        step();
        chk("rt_cnt", bus.stall_count_o, 16'd2);

        // WB bypass into both operands
        bus.wb_RegWrite_i = 1; bus.wb_WriteRegister_i = 5'd9; bus.wb_WriteData_i = 32'h55AA;
        id_in(5'd9, 5'd9, 5'd7, 1'b1, 32'h11, 32'h0, 32'h0, 1'b1, 1'b0, 8'h04, 1'b0);
        step();
        chk("byp_rd2", bus.ex_ReadData2_o, BYP ? 32'h55AA : 32'h0);
        chk("byp_rd1", bus.ex_ReadData1_o, BYP ? 32'h55AA : 32'h11);
        bus.wb_WriteRegister_i = 5'd0;
        id_in(5'd0, 5'd0, 5'd7, 1'b1, 32'h22, 32'h33, 32'h0, 1'b1, 1'b0, 8'h05, 1'b0);
        step();
        chk("byp_r0", bus.ex_ReadData1_o, 32'h22);
        bus.wb_RegWrite_i = 0;

        // Five more stalls: 16-bit counter reaches 7, 2-bit counter pins at 3
        for (int i = 0; i < 5; i++) begin
            lw(5'd5);
            step();
            id_in(5'd5, 5'd6, 5'd7, 1'b0, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 8'h06, 1'b0);
            step();
            step();
        end
        chk("sat_cnt16", bus.stall_count_o, 16'd7);
        chk("sat_cnt2", bus2.stall_count_o, 2'd3);

        // Reset asserted mid-stall, between clock edges
        lw(5'd16);
        step();
        id_in(5'd16, 5'd2, 5'd3, 1'b1, 32'h77, 32'h88, 32'h0, 1'b1, 1'b0, 8'h11, 1'b0);
        #1 chk("mr_stall_pre", bus.stall_o, 1'b1);
        reset = 1'b1;
        #1;
        chk("mr_stall", bus.stall_o, 1'b0);
        chk("mr_valid", bus.ex_valid_o, 1'b0);
        chk("mr_rd1", bus.ex_ReadData1_o, 32'h0);
        chk("mr_mr", bus.ex_MemRead_o, 1'b0);
        chk("mr_cnt", bus.stall_count_o, 16'd0);
        chk("mr_cnt2", bus2.stall_count_o, 2'd0);
        #4;
        reset = 1'b0;
        step();
        chk("post_valid", bus.ex_valid_o, 1'b1);
        chk("post_rs", bus.ex_rs_o, 5'd16);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
